preamble_sync: RTL and testbench
================================

Name: preamble_sync

Overview:
Receive-side companion to the preamble inserter; sits directly downstream of it on the 32-bit valid/ready stream. Searches the incoming stream for a run of preamble_length consecutive words equal to preamble_value, strips that run, then forwards exactly frame_length payload words marked with frame start/last flags. After the last payload word it returns to searching. Counts completed frames and flags configuration errors.

Parameters:
DATA_WIDTH, 32, stream word width
CNT_WIDTH, 32, width of preamble_length, frame_length and internal counters
FCOUNT_WIDTH, 16, width of frame_count
TIMEOUT_CYCLES, 256, idle-cycle limit inside a frame (optional feature only)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-low reset
signal_in  in  DATA_WIDTH  input word
valid_in  in  1  input word valid
ready_out  out  1  block can accept signal_in
preamble_value  in  DATA_WIDTH  preamble word to match
preamble_length  in  CNT_WIDTH  required consecutive preamble words
frame_length  in  CNT_WIDTH  payload words per frame
signal_out  out  DATA_WIDTH  payload word
valid_out  out  1  signal_out valid
ready_in  in  1  downstream accepts signal_out
frame_start  out  1  qualifies first payload word (with valid_out)
frame_last  out  1  qualifies last payload word (with valid_out)
locked  out  1  high while in PAYLOAD state
frame_count  out  FCOUNT_WIDTH  completed frames, wraps
error  out  1  sticky configuration error

Behaviour:
- Reset (rst==0 at clk edge): state=SEARCH, match_cnt=0, pay_cnt=0, valid_out=0, signal_out=0, frame_start=0, frame_last=0, locked=0, frame_count=0, error=0. Reset mid-frame discards the frame, no flags.
- Input accept: word taken when valid_in && ready_out. ready_out = !valid_out || ready_in (single output register, no skid). ready_out=0 during reset.
- Config sampled at each accepted word; must be static during a frame.
- SEARCH: accepted word == preamble_value -> match_cnt+1; else match_cnt=0. Preamble words never forwarded. When match_cnt+1 == preamble_length -> PAYLOAD, pay_cnt=0, match_cnt=0.
- PAYLOAD: every accepted word is payload regardless of value (payload may equal preamble_value). Loaded into output register: frame_start = (pay_cnt==0), frame_last = (pay_cnt==frame_length-1). On last word -> SEARCH, frame_count+1 (wraps at 2^FCOUNT_WIDTH).
- Latency: accepted payload word appears on signal_out next cycle; held stable while valid_out && !ready_in.
- Back-to-back frames: preamble of next frame may be accepted the cycle after last payload word; no dead cycle required.
- Config error: preamble_length==0 or frame_length==0 at an accepted word -> error=1 (sticky until reset), state forced SEARCH, word dropped, nothing forwarded.
- frame_length==1: frame_start and frame_last both high on the single word.
- locked = (state==PAYLOAD), registered.

Optional Feature:
PREAMBLE_SYNC_TIMEOUT_EN
- Defined: idle counter runs in PAYLOAD, cleared on each accepted word; reaching TIMEOUT_CYCLES with no accepted word -> abort frame, return to SEARCH, one-cycle pulse on extra output port abort (1 bit, reset 0), frame_count not incremented. Any word already in output register still drains normally.
- Undefined: no counter, no abort port; PAYLOAD waits indefinitely.

Decomposition:
- Package preamble_pkg: state enum (SEARCH, PAYLOAD), DATA_WIDTH/CNT_WIDTH defaults, shared with the inserter.
- One natural sub-module: preamble_match_cnt (compare + saturating run counter + terminal flag); output register stays in top.

Test Plan:
- preamble 23, length 5, frame 16; feed 23x5 then 0..15 continuously, ready_in=1 -> 16 outputs 0..15, frame_start on 0, frame_last on 15, frame_count=1, locked high 16 cycles.
- 23,23,23,7,23x5 then 16 words -> partial run discarded, single frame detected, 7 not forwarded.
- Payload containing 23 at word 0 and word 23-valued words mid-frame -> all forwarded, no resync.
- ready_in toggled 1/0 each cycle during payload -> no word lost or duplicated, signal_out stable while stalled, order 0..15.
- frame_length=0 -> error=1 after first accepted word, valid_out never asserted; rst low one cycle -> error=0.
- With PREAMBLE_SYNC_TIMEOUT_EN, TIMEOUT_CYCLES=8: stop valid_in after 4 payload words for 8 cycles -> abort pulse, locked=0, frame_count unchanged; next preamble+frame received correctly.

Source files
------------

// File: rtl/preamble_pkg.sv
// Shared definitions for the preamble inserter/synchroniser pair on the 32-bit valid/ready stream.
package preamble_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CNT_WIDTH  = 32;

    typedef enum logic {
        SEARCH  = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

endpackage

// File: rtl/preamble_match_cnt.sv
// Preamble run detector: compares each enabled word with the pattern, tracks the current run length,
// and flags the word that completes a run of i_length matches.
module preamble_match_cnt
    import preamble_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_clear,
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic [DATA_WIDTH-1:0] i_pattern,
    input  logic [CNT_WIDTH-1:0]  i_length,
    output logic                  o_hit
);

    logic [CNT_WIDTH-1:0] r_run;
    logic [CNT_WIDTH-1:0] w_next;
    logic                 w_match;
    logic                 w_sat;

    assign w_match = (i_word == i_pattern);
    assign w_next  = r_run + CNT_WIDTH'(1);
    assign w_sat   = &r_run;

    // A saturated run can never complete, so it is excluded from the terminal test.
    assign o_hit = i_en && w_match && !w_sat && (w_next == i_length);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_run <= '0;
        end else if (i_clear) begin
            r_run <= '0;
        end else if (i_en) begin
            if (!w_match || o_hit) begin
                r_run <= '0;
            end else if (!w_sat) begin
                r_run <= w_next;
            end
        end
    end

endmodule

// File: rtl/preamble_sync.sv
// Receive-side preamble synchroniser: strips a run of preamble words and forwards one framed payload.
// Optional idle-timeout abort inside a frame is enabled with `define PREAMBLE_SYNC_TIMEOUT_EN.
module preamble_sync
    import preamble_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int FCOUNT_WIDTH   = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   signal_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic [DATA_WIDTH-1:0]   preamble_value,
    input  logic [CNT_WIDTH-1:0]    preamble_length,
    input  logic [CNT_WIDTH-1:0]    frame_length,
    output logic [DATA_WIDTH-1:0]   signal_out,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic                    frame_start,
    output logic                    frame_last,
    output logic                    locked,
    output logic [FCOUNT_WIDTH-1:0] frame_count,
    output logic                    error
`ifdef PREAMBLE_SYNC_TIMEOUT_EN
    ,
    output logic                    abort
`endif
);

    state_t                  r_state;
    logic [CNT_WIDTH-1:0]    r_pay_cnt;
    logic [DATA_WIDTH-1:0]   r_signal_out;
    logic                    r_valid_out;
    logic                    r_frame_start;
    logic                    r_frame_last;
    logic                    r_locked;
    logic [FCOUNT_WIDTH-1:0] r_frame_count;
    logic                    r_error;
`ifdef PREAMBLE_SYNC_TIMEOUT_EN
    logic [CNT_WIDTH-1:0]    r_idle;
    logic                    r_abort;
`endif

    logic w_ready;
    logic w_accept;
    logic w_cfg_err;
    logic w_hit;
    logic w_pay_last;

    // Single output register without skid buffer: accept only when it is empty or draining.
    assign w_ready    = rst && (!r_valid_out || ready_in);
    assign w_accept   = valid_in && w_ready;
    assign w_cfg_err  = (preamble_length == '0) || (frame_length == '0);
    assign w_pay_last = (r_pay_cnt == frame_length - CNT_WIDTH'(1));

    preamble_match_cnt #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_match (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_accept && !w_cfg_err && (r_state == SEARCH)),
        .i_clear   (w_accept && w_cfg_err),
        .i_word    (signal_in),
        .i_pattern (preamble_value),
        .i_length  (preamble_length),
        .o_hit     (w_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= SEARCH;
            r_pay_cnt     <= '0;
            r_signal_out  <= '0;
            r_valid_out   <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_last  <= 1'b0;
            r_locked      <= 1'b0;
            r_frame_count <= '0;
            r_error       <= 1'b0;
`ifdef PREAMBLE_SYNC_TIMEOUT_EN
            r_idle        <= '0;
            r_abort       <= 1'b0;
`endif
        end else begin
            if (r_valid_out && ready_in) begin
                r_valid_out   <= 1'b0;
                r_frame_start <= 1'b0;
                r_frame_last  <= 1'b0;
            end

            if (w_accept) begin
                if (w_cfg_err) begin
                    r_error   <= 1'b1;
                    r_state   <= SEARCH;
                    r_locked  <= 1'b0;
                    r_pay_cnt <= '0;
                end else if (r_state == SEARCH) begin
                    if (w_hit) begin
                        r_state   <= PAYLOAD;
                        r_locked  <= 1'b1;
                        r_pay_cnt <= '0;
                    end
                end else begin
                    // Every word inside a frame is payload, even if it equals the preamble value.
                    r_signal_out  <= signal_in;
                    r_valid_out   <= 1'b1;
                    r_frame_start <= (r_pay_cnt == '0);
                    r_frame_last  <= w_pay_last;
                    if (w_pay_last) begin
                        r_state       <= SEARCH;
                        r_locked      <= 1'b0;
                        r_pay_cnt     <= '0;
                        r_frame_count <= r_frame_count + FCOUNT_WIDTH'(1);
                    end else begin
                        r_pay_cnt <= r_pay_cnt + CNT_WIDTH'(1);
                    end
                end
            end

`ifdef PREAMBLE_SYNC_TIMEOUT_EN
            r_abort <= 1'b0;
            if ((r_state == PAYLOAD) && !w_accept) begin
                if (r_idle == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    r_state   <= SEARCH;
                    r_locked  <= 1'b0;
                    r_pay_cnt <= '0;
                    r_idle    <= '0;
                    r_abort   <= 1'b1;
                end else begin
                    r_idle <= r_idle + CNT_WIDTH'(1);
                end
            end else begin
                r_idle <= '0;
            end
`endif
        end
    end

    assign ready_out   = w_ready;
    assign signal_out  = r_signal_out;
    assign valid_out   = r_valid_out;
    assign frame_start = r_frame_start;
    assign frame_last  = r_frame_last;
    assign locked      = r_locked;
    assign frame_count = r_frame_count;
    assign error       = r_error;
`ifdef PREAMBLE_SYNC_TIMEOUT_EN
    assign abort       = r_abort;
`endif

endmodule

// File: tb/tb_preamble_sync.sv
// Directed scoreboard bench for preamble_sync; also exercises the abort path when PREAMBLE_SYNC_TIMEOUT_EN is defined.
module tb_preamble_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] signal_in;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] preamble_value;
    logic [31:0] preamble_length;
    logic [31:0] frame_length;
    logic [31:0] signal_out;
    logic        valid_out;
    logic        ready_in;
    logic        frame_start;
    logic        frame_last;
    logic        locked;
    logic [15:0] frame_count;
    logic        error;
`ifdef PREAMBLE_SYNC_TIMEOUT_EN
    logic        abort;
`endif

    int          errors = 0;
    int          checks = 0;
    int          lockedCycles = 0;
    logic [33:0] expQ[$];
    logic        toggleReady = 1'b0;
    logic        prevStall = 1'b0;
    logic [31:0] prevData = '0;

    preamble_sync #(.TIMEOUT_CYCLES(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .signal_in       (signal_in),
        .valid_in        (valid_in),
        .ready_out       (ready_out),
        .preamble_value  (preamble_value),
        .preamble_length (preamble_length),
        .frame_length    (frame_length),
        .signal_out      (signal_out),
        .valid_out       (valid_out),
        .ready_in        (ready_in),
        .frame_start     (frame_start),
        .frame_last      (frame_last),
        .locked          (locked),
        .frame_count     (frame_count),
        .error           (error)
`ifdef PREAMBLE_SYNC_TIMEOUT_EN
        ,
        .abort           (abort)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Output side, sampled at the falling edge: stall stability and scoreboard pops.
    task automatic monitor();
        logic [33:0] exp;
        if (!rst) begin
            prevStall = 1'b0;
            return;
        end
        if (prevStall) begin
            checkOutput("stall_hold_data", {32'd0, signal_out}, {32'd0, prevData});
            checkOutput("stall_hold_valid", {63'd0, valid_out}, 64'd1);
        end
        if (valid_out && ready_in) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $error("[TB] FAIL unexpected_output: observed=%0h expected=none", signal_out);
            end else begin
                exp = expQ.pop_front();
                checkOutput("payload", {30'd0, signal_out, frame_start, frame_last}, {30'd0, exp});
            end
        end
        if (locked) lockedCycles++;
        prevStall = valid_out && !ready_in;
        prevData  = signal_out;
    endtask

    task automatic tick(output logic rdy);
        @(negedge clk);
        rdy = ready_out;
        monitor();
        @(posedge clk);
        #1;
        if (toggleReady) ready_in = !ready_in;
    endtask

    task automatic applyStimulus(input logic [31:0] data, input bit isPayload, input bit isStart, input bit isLast);
        logic rdy;
        bit   got;
        got       = 1'b0;
        signal_in = data;
        valid_in  = 1'b1;
        for (int n = 0; n < 100 && !got; n++) begin
            tick(rdy);
            got = rdy;
        end
        valid_in = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $error("[TB] FAIL accept_timeout: observed=no_accept expected=accept data=%0h", data);
        end else if (isPayload) begin
            expQ.push_back({data, isStart, isLast});
        end
    endtask

    task automatic sendPreamble(input int n);
        for (int i = 0; i < n; i++) applyStimulus(32'd23, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sendPayload(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) applyStimulus(base + 32'(i), 1'b1, i == 0, i == n - 1);
    endtask

    task automatic waitDrain();
        logic rdy;
        for (int n = 0; n < 60 && expQ.size() != 0; n++) tick(rdy);
        checkOutput("drain", 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        logic rdy;
        int   lockStart;
        logic [31:0] word;
        rst             = 1'b0;
        signal_in       = '0;
        valid_in        = 1'b0;
        ready_in        = 1'b1;
        preamble_value  = 32'd23;
        preamble_length = 32'd5;
        frame_length    = 32'd16;

        tick(rdy);
        tick(rdy);
        checkOutput("ready_in_reset", {63'd0, ready_out}, 64'd0);
        rst = 1'b1;
        tick(rdy);
        checkOutput("reset_valid", {63'd0, valid_out}, 64'd0);
        checkOutput("reset_data", {32'd0, signal_out}, 64'd0);
        checkOutput("reset_locked", {63'd0, locked}, 64'd0);
        checkOutput("reset_fcount", {48'd0, frame_count}, 64'd0);
        checkOutput("reset_error", {63'd0, error}, 64'd0);

        $display("[TB] basic frame");
        lockStart = lockedCycles;
        sendPreamble(5);
        sendPayload(32'd0, 16);
        waitDrain();
        checkOutput("basic_fcount", {48'd0, frame_count}, 64'd1);
        checkOutput("basic_locked_cycles", 64'(lockedCycles - lockStart), 64'd16);
        checkOutput("basic_locked_after", {63'd0, locked}, 64'd0);

        $display("[TB] broken preamble run");
        sendPreamble(3);
        applyStimulus(32'd7, 1'b0, 1'b0, 1'b0);
        sendPreamble(5);
        sendPayload(32'd100, 16);
        waitDrain();
        checkOutput("partial_fcount", {48'd0, frame_count}, 64'd2);

        $display("[TB] preamble-valued payload");
        sendPreamble(5);
        for (int i = 0; i < 16; i++) begin
            word = (i == 0 || i == 5 || i == 6 || i == 12) ? 32'd23 : 32'(200 + i);
            applyStimulus(word, 1'b1, i == 0, i == 15);
        end
        waitDrain();
        checkOutput("embedded_fcount", {48'd0, frame_count}, 64'd3);

        $display("[TB] downstream stall toggling");
        toggleReady = 1'b1;
        sendPreamble(5);
        sendPayload(32'd0, 16);
        waitDrain();
        toggleReady = 1'b0;
        ready_in    = 1'b1;
        checkOutput("stall_fcount", {48'd0, frame_count}, 64'd4);

        $display("[TB] single-word frame");
        frame_length = 32'd1;
        sendPreamble(5);
        applyStimulus(32'hAA, 1'b1, 1'b1, 1'b1);
        waitDrain();
        checkOutput("single_fcount", {48'd0, frame_count}, 64'd5);
        checkOutput("single_locked", {63'd0, locked}, 64'd0);

        $display("[TB] configuration error");
        frame_length = 32'd0;
        checkOutput("cfg_error_before", {63'd0, error}, 64'd0);
        applyStimulus(32'd23, 1'b0, 1'b0, 1'b0);
        tick(rdy);
        tick(rdy);
        checkOutput("cfg_error_set", {63'd0, error}, 64'd1);
        checkOutput("cfg_error_valid", {63'd0, valid_out}, 64'd0);
        rst = 1'b0;
        tick(rdy);
        rst = 1'b1;
        checkOutput("cfg_error_cleared", {63'd0, error}, 64'd0);
        checkOutput("cfg_fcount_cleared", {48'd0, frame_count}, 64'd0);
        frame_length = 32'd16;

`ifdef PREAMBLE_SYNC_TIMEOUT_EN
        begin
            bit seen;
            $display("[TB] idle timeout abort");
            seen = 1'b0;
            sendPreamble(5);
            sendPayload(32'd50, 4);
            for (int n = 0; n < 20 && !seen; n++) begin
                tick(rdy);
                if (abort) seen = 1'b1;
            end
            checkOutput("abort_seen", {63'd0, seen}, 64'd1);
            tick(rdy);
            checkOutput("abort_pulse_end", {63'd0, abort}, 64'd0);
            checkOutput("abort_locked", {63'd0, locked}, 64'd0);
            checkOutput("abort_fcount", {48'd0, frame_count}, 64'd0);
            waitDrain();
            sendPreamble(5);
            sendPayload(32'd300, 16);
            waitDrain();
            checkOutput("after_abort_fcount", {48'd0, frame_count}, 64'd1);
        end
`endif

        tick(rdy);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
